rdata_rsp_ctrl: RTL and testbench
=================================

# rdata_rsp_ctrl

Read-response sequencer on the AXI side of the axi_to_ahb bridge. Queues accepted read commands (ID, length, error flag), drains the 64-bit read-data FIFO one beat per cycle, and presents the beats on a registered AXI4 R channel with correct RID, RRESP and RLAST. Commands flagged as errored produce synthesized zero-data beats without touching the FIFO.

## Interface
- ID_W, 4, AXI ID width
- CMD_DEPTH, 4, outstanding-command queue depth (power of two, ≥2)
- rclk  in  1  read-side clock (same clock as the rdata FIFO read port)
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  read command offered
- cmd_ready  out  1  command queue not full
- cmd_id  in  ID_W  ARID of the burst
- cmd_len  in  8  ARLEN (beats − 1)
- cmd_err  in  1  1 = decode/AHB error; all beats carry SLVERR and zero data
- fifo_empty  in  1  rdata FIFO empty flag
- fifo_data  in  64  rdata FIFO output (valid in the same cycle as fifo_read_en)
- fifo_read_en  out  1  pop strobe to the rdata FIFO
- r_valid  out  1  R beat valid
- r_ready  in  1  R beat accepted
- r_data  out  64  R data
- r_id  out  ID_W  RID
- r_resp  out  2  2'b00 OKAY or 2'b10 SLVERR
- r_last  out  1  final beat of the burst
- busy  out  1  state ≠ IDLE, queue non-empty, or r_valid high

## Operation
- Command queue: sync FIFO of {id, len, err}, CMD_DEPTH entries. Push on cmd_valid && cmd_ready. cmd_ready = !full; it is not dependent on cmd_valid.
- Output register (r_*) load enable: ld = !r_valid || r_ready.
- FSM states:
  - IDLE: if queue non-empty, pop one entry into cur_id/cur_len/cur_err, clear beat_cnt, go to BURST (cur_err=0) or ERR (cur_err=1). Otherwise stay.
  - BURST: fifo_read_en = ld && !fifo_empty. On a pop, load r_data=fifo_data, r_id=cur_id, r_resp=OKAY, r_last=(beat_cnt==cur_len), r_valid=1, beat_cnt+1. The pop of the last beat returns to IDLE.
  - ERR: fifo_read_en=0. On every ld, load r_data=0, r_resp=SLVERR, r_last=(beat_cnt==cur_len), r_valid=1, beat_cnt+1. The last beat returns to IDLE.
- If ld holds and no new beat is loaded, r_valid clears. r_* fields hold while r_valid && !r_ready.
- beat_cnt is 8 bits and is compared for equality only. cur_len=255 gives 256 beats with no wrap issue.
- The FIFO is never popped while r_valid && !r_ready. The FIFO is never popped when fifo_empty=1. fifo_read_en is gated with !reset.
- Simultaneous push and pop on the queue is allowed, including when the queue is full (the pop frees the slot for the next cycle only).
- Reset mid-burst: all state is discarded. Remaining FIFO contents are not flushed by this block. Flushing the FIFO is the bridge's responsibility.

## Timing
- Reset values: r_valid=0, r_data=0, r_id=0, r_resp=0, r_last=0, fifo_read_en=0, cmd_ready=1, busy=0, FSM=IDLE, queue empty.
- Command latency (queue empty, FIFO non-empty, r_ready=1):
  - cmd handshake at edge E0.
  - IDLE pop at E1; FSM in BURST after E1.
  - fifo_read_en high in the cycle after E1.
  - r_valid high after E2.
- Throughput: 1 beat/cycle while the FIFO is non-empty and r_ready=1.
- Exactly one IDLE cycle separates consecutive bursts.
- ERR burst: first r_valid two edges after the command reaches the queue head, then 1 beat/cycle.

## Structure
- Package rdata_rsp_pkg holds:
  - RESP_OKAY = 2'b00
  - RESP_SLVERR = 2'b10
  - state enum {IDLE, BURST, ERR}
  - typedef rsp_cmd_t {id, len, err}
- One sub-module, rsp_cmd_fifo: parameterized single-clock FIFO with sync active-high reset, count-based full/empty. The FSM and output register live in the top.

## Test plan
- Single burst: cmd id=3 len=3 err=0; FIFO preloaded with 0xA0..0xA3; r_ready=1 → 4 consecutive beats with data A0..A3, r_id=3, OKAY, r_last on beat 4 only; exactly 4 pops; first r_valid 2 edges after E0.
- Backpressure: same burst with r_ready toggling 1,0,0,1,… → r_* stable while stalled, no pop during stalls, data order preserved, total pops=4.
- FIFO starvation: len=7, FIFO fed one word every 3 cycles → r_valid gaps, no pop while fifo_empty=1, r_last on beat 8.
- Error burst: cmd id=5 len=2 err=1 with FIFO non-empty → 3 beats with data 0, SLVERR, id=5; fifo_read_en never asserted.
- Queue full and back-to-back: issue 5 commands (lens 0,1,0,255,0) with r_ready=1 → cmd_ready drops after 4 until the first dequeue; bursts come out in order with a 1-cycle gap each; the 256-beat burst has r_last on beat 256 only.
- Reset mid-burst: assert reset at beat 2 of a len=7 burst → the next cycle shows r_valid=0, fifo_read_en=0, cmd_ready=1, busy=0; a new len=0 command then completes normally.

Source files
------------

// File: rtl/rdata_rsp_ctrl_pkg.sv
// Shared response codes, FSM encoding and queued-command record for the read-response sequencer.
package rdata_rsp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

  // Widest ARID the queue record can carry; narrower IDs are zero-extended on push.
  localparam int CMD_ID_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    BURST = ST_BURST,
    ERR   = ST_ERR
  } rsp_state_e;

  typedef struct packed {
    logic [CMD_ID_MAX_W-1:0] id;
    logic [7:0]              len;
    logic                    err;
  } rsp_cmd_t;

endpackage

// File: rtl/rdata_rsp_ctrl_cmd_fifo.sv
// Single-clock show-ahead FIFO, count-based full/empty, no read latency.
// Push is dropped when full and pop is dropped when empty; the caller gates with the flags.
module rsp_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign pop_dat = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: rtl/rdata_rsp_ctrl.sv
// Read-response sequencer: queues read commands, drains the rdata FIFO onto a registered R channel.
// First beat 2 edges after the command handshake; R stalls hold r_* and suppress FIFO pops.
module rdata_rsp_ctrl
  import rdata_rsp_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int CMD_DEPTH = 4
) (
  input  logic            rclk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [ID_W-1:0] cmd_id,
  input  logic [7:0]      cmd_len,
  input  logic            cmd_err,
  input  logic            fifo_empty,
  input  logic [63:0]     fifo_data,
  output logic            fifo_read_en,
  output logic            r_valid,
  input  logic            r_ready,
  output logic [63:0]     r_data,
  output logic [ID_W-1:0] r_id,
  output logic [1:0]      r_resp,
  output logic            r_last,
  output logic            busy
);

  rsp_cmd_t push_cmd;
  rsp_cmd_t head_cmd;
  logic     q_push;
  logic     q_pop;
  logic     q_full;
  logic     q_empty;
  logic     unused_id_hi;

  rsp_state_e      state_q, state_d;
  logic [ID_W-1:0] cur_id_q, cur_id_d;
  logic [7:0]      cur_len_q, cur_len_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;

  logic            r_valid_q, r_valid_d;
  logic [63:0]     r_data_q, r_data_d;
  logic [ID_W-1:0] r_id_q, r_id_d;
  logic [1:0]      r_resp_q, r_resp_d;
  logic            r_last_q, r_last_d;

  logic ld;
  logic fifo_pop;
  logic last_beat;

  always_comb begin
    push_cmd             = '0;
    push_cmd.id[ID_W-1:0] = cmd_id;
    push_cmd.len         = cmd_len;
    push_cmd.err         = cmd_err;
  end

  assign cmd_ready    = !q_full;
  assign q_push       = cmd_valid && cmd_ready;
  assign unused_id_hi = ^head_cmd.id;

  rsp_cmd_fifo #(
    .W     ($bits(rsp_cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk      (rclk),
    .reset    (reset),
    .push     (q_push),
    .push_dat (push_cmd),
    .pop      (q_pop),
    .pop_dat  (head_cmd),
    .full     (q_full),
    .empty    (q_empty)
  );

  // The output register may take a new beat when it is empty or being drained this cycle.
  assign ld        = !r_valid_q || r_ready;
  assign last_beat = (beat_cnt_q == cur_len_q);

  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    cur_len_d  = cur_len_q;
    beat_cnt_d = beat_cnt_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_id_d     = r_id_q;
    r_resp_d   = r_resp_q;
    r_last_d   = r_last_q;
    q_pop      = 1'b0;
    fifo_pop   = 1'b0;

    if (ld) begin
      r_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          q_pop      = 1'b1;
          cur_id_d   = head_cmd.id[ID_W-1:0];
          cur_len_d  = head_cmd.len;
          beat_cnt_d = '0;
          state_d    = head_cmd.err ? ERR : BURST;
        end
      end
      BURST: begin
        fifo_pop = ld && !fifo_empty;
        if (fifo_pop) begin
          r_valid_d  = 1'b1;
          r_data_d   = fifo_data;
          r_id_d     = cur_id_q;
          r_resp_d   = RESP_OKAY;
          r_last_d   = last_beat;
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      ERR: begin
        // Errored bursts synthesize zero beats and never consume FIFO data.
        if (ld) begin
          r_valid_d  = 1'b1;
          r_data_d   = '0;
          r_id_d     = cur_id_q;
          r_resp_d   = RESP_SLVERR;
          r_last_d   = last_beat;
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_id_q   <= '0;
      cur_len_q  <= '0;
      beat_cnt_q <= '0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_id_q     <= '0;
      r_resp_q   <= RESP_OKAY;
      r_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      cur_len_q  <= cur_len_d;
      beat_cnt_q <= beat_cnt_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_id_q     <= r_id_d;
      r_resp_q   <= r_resp_d;
      r_last_q   <= r_last_d;
    end
  end

  assign fifo_read_en = fifo_pop && !reset;
  assign r_valid      = r_valid_q;
  assign r_data       = r_data_q;
  assign r_id         = r_id_q;
  assign r_resp       = r_resp_q;
  assign r_last       = r_last_q;
  assign busy         = (state_q != IDLE) || !q_empty || r_valid_q;

endmodule

// File: tb/tb_rdata_rsp_ctrl.sv
// Bench for rdata_rsp_ctrl: directed commands, a model rdata FIFO and a scoreboard-driven R monitor.
module tb_rdata_rsp_ctrl;
  import rdata_rsp_pkg::*;

  localparam int ID_W      = 4;
  localparam int CMD_DEPTH = 4;

  typedef struct {
    logic [63:0]     data;
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
    logic            last;
  } beat_t;

  logic            rclk = 1'b0;
  logic            reset = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [ID_W-1:0] cmd_id = '0;
  logic [7:0]      cmd_len = '0;
  logic            cmd_err = 1'b0;
  logic            fifo_empty = 1'b1;
  logic [63:0]     fifo_data = '0;
  logic            fifo_read_en;
  logic            r_valid;
  logic            r_ready = 1'b1;
  logic [63:0]     r_data;
  logic [ID_W-1:0] r_id;
  logic [1:0]      r_resp;
  logic            r_last;
  logic            busy;

  rdata_rsp_ctrl #(.ID_W(ID_W), .CMD_DEPTH(CMD_DEPTH)) dut (
    .rclk         (rclk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_id       (cmd_id),
    .cmd_len      (cmd_len),
    .cmd_err      (cmd_err),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_data       (r_data),
    .r_id         (r_id),
    .r_resp       (r_resp),
    .r_last       (r_last),
    .busy         (busy)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  beat_t       exp_q[$];
  logic [63:0] mdl[$];
  logic [63:0] load_seq = '0;
  logic [63:0] exp_seq = '0;
  int pops = 0, hs_cnt = 0, viol_empty = 0, viol_stall = 0, gaps = 0;
  int feed_left = 0, rr_mode = 0, first_hs = 0, last_hs = 0;
  logic        pop_now = 1'b0;
  logic        prev_stall = 1'b0;
  logic [71:0] prev_snap = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic void fifo_refresh();
    fifo_empty = (mdl.size() == 0);
    fifo_data  = (mdl.size() == 0) ? 64'h0 : mdl[0];
  endfunction

  initial forever begin
    @(posedge rclk);
    cyc++;
  end

  initial forever begin
    @(posedge rclk);
    #1;
    r_ready = (rr_mode == 0) ? 1'b1 : (cyc % 3 == 0);
  end

  // Model rdata FIFO: pops decided at the preceding falling edge, applied just after the rising edge.
  initial forever begin
    @(posedge rclk);
    #1;
    if (pop_now) begin
      pops++;
      if (mdl.size() > 0) void'(mdl.pop_front());
    end
    if (feed_left > 0 && cyc % 3 == 0) begin
      mdl.push_back(load_seq);
      load_seq++;
      feed_left--;
    end
    fifo_refresh();
  end

  // R monitor: compares every accepted beat against the scoreboard head.
  initial begin
    beat_t e;
    forever begin
      @(negedge rclk);
      pop_now = fifo_read_en;
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (fifo_read_en && fifo_empty) viol_empty++;
        if (fifo_read_en && r_valid && !r_ready) viol_stall++;
        if (prev_stall && {r_valid, r_data, r_id, r_resp, r_last} !== prev_snap) viol_stall++;
        prev_stall = r_valid && !r_ready;
        prev_snap  = {r_valid, r_data, r_id, r_resp, r_last};
        if (busy && !r_valid) gaps++;
        if (r_valid && r_ready) begin
          hs_cnt++;
          if (hs_cnt == 1) first_hs = cyc;
          last_hs = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL r_beat: unexpected beat data=%0h id=%0h, scoreboard empty", r_data, r_id);
          end else begin
            e = exp_q.pop_front();
            check("r_data", r_data, e.data);
            check("r_id", 64'(r_id), 64'(e.id));
            check("r_resp", 64'(r_resp), 64'(e.resp));
            check("r_last", 64'(r_last), 64'(e.last));
          end
        end
      end
    end
  end

  task automatic new_test(input logic [63:0] base);
    pops = 0; hs_cnt = 0; viol_empty = 0; viol_stall = 0; gaps = 0;
    load_seq = base;
    exp_seq  = base;
    mdl.delete();
    fifo_refresh();
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      mdl.push_back(load_seq);
      load_seq++;
    end
    fifo_refresh();
  endtask

  task automatic expect_burst(input logic [ID_W-1:0] id, input int len, input logic err);
    for (int i = 0; i <= len; i++) begin
      beat_t b;
      b.data = err ? 64'h0 : exp_seq;
      if (!err) exp_seq++;
      b.id   = id;
      b.resp = err ? RESP_SLVERR : RESP_OKAY;
      b.last = (i == len);
      exp_q.push_back(b);
    end
  endtask

  task automatic issue(input logic [ID_W-1:0] id, input logic [7:0] len, input logic err, output int e0);
    cmd_valid = 1'b1; cmd_id = id; cmd_len = len; cmd_err = err;
    e0 = -1;
    for (int i = 0; i < 600 && e0 < 0; i++) begin
      @(negedge rclk);
      if (cmd_ready) begin
        @(posedge rclk); #1;
        e0 = cyc;
      end else begin
        @(posedge rclk); #1;
      end
    end
    cmd_valid = 1'b0;
    if (e0 < 0) begin
      checks++;
      $display("FAIL cmd_accept: id=%0h never accepted, required acceptance", id);
    end
  endtask

  task automatic check_latency(input string name, input int e0);
    int seen = -1;
    for (int i = 0; i < 20 && seen < 0; i++) begin
      @(negedge rclk);
      if (r_valid) seen = cyc;
    end
    check(name, 64'(seen - e0), 64'd2);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    do begin
      @(posedge rclk); #1;
      n++;
    end while (busy && n < bound);
    if (busy) begin
      checks++;
      $display("FAIL %s_timeout: busy=1 after %0d cycles, required 0", name, bound);
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  int e0;
  int nready;

  initial begin
    repeat (3) @(posedge rclk);
    #1;
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_r_data", r_data, 64'd0);
    check("rst_r_id", 64'(r_id), 64'd0);
    check("rst_r_resp", 64'(r_resp), 64'd0);
    check("rst_r_last", 64'(r_last), 64'd0);
    check("rst_fifo_read_en", 64'(fifo_read_en), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(posedge rclk); #1;

    // Single burst, data A0..A3
    new_test(64'hA0);
    load_words(4);
    expect_burst(4'd3, 3, 1'b0);
    issue(4'd3, 8'd3, 1'b0, e0);
    check_latency("single_latency", e0);
    wait_idle("single", 50);
    check("single_pops", 64'(pops), 64'd4);
    check("single_span", 64'(last_hs - first_hs), 64'd3);

    // Backpressure with r_ready 1,0,0 repeating
    rr_mode = 1;
    new_test(64'hB0);
    load_words(4);
    expect_burst(4'd3, 3, 1'b0);
    issue(4'd3, 8'd3, 1'b0, e0);
    wait_idle("bp", 80);
    check("bp_stall_violations", 64'(viol_stall), 64'd0);
    check("bp_pops", 64'(pops), 64'd4);
    rr_mode = 0;
    @(posedge rclk); #1;

    // FIFO starvation: one word every 3 cycles
    new_test(64'h300);
    expect_burst(4'd6, 7, 1'b0);
    feed_left = 8;
    issue(4'd6, 8'd7, 1'b0, e0);
    wait_idle("starve", 100);
    check("starve_pop_when_empty", 64'(viol_empty), 64'd0);
    check("starve_pops", 64'(pops), 64'd8);
    check("starve_gaps_seen", 64'(gaps > 0), 64'd1);

    // Error burst with a word waiting in the FIFO
    new_test(64'h400);
    load_words(1);
    expect_burst(4'd5, 2, 1'b1);
    issue(4'd5, 8'd2, 1'b1, e0);
    check_latency("err_latency", e0);
    wait_idle("err", 50);
    check("err_pops", 64'(pops), 64'd0);
    check("err_fifo_untouched", 64'(mdl.size()), 64'd1);

    // Queue full, back-to-back; first command leaves the queue one edge after acceptance
    new_test(64'h1000);
    expect_burst(4'd1, 0, 1'b0);   issue(4'd1, 8'd0, 1'b0, e0);
    expect_burst(4'd2, 1, 1'b0);   issue(4'd2, 8'd1, 1'b0, e0);
    expect_burst(4'd3, 0, 1'b0);   issue(4'd3, 8'd0, 1'b0, e0);
    expect_burst(4'd4, 255, 1'b0); issue(4'd4, 8'd255, 1'b0, e0);
    expect_burst(4'd5, 0, 1'b0);   issue(4'd5, 8'd0, 1'b0, e0);
    check("qfull_cmd_ready_low", 64'(cmd_ready), 64'd0);
    check("qfull_busy", 64'(busy), 64'd1);
    load_words(261);
    nready = 0;
    for (int i = 0; i < 20 && nready == 0; i++) begin
      @(negedge rclk);
      if (cmd_ready) nready = 1;
    end
    check("qfull_cmd_ready_return", 64'(nready), 64'd1);
    wait_idle("qfull", 600);
    check("qfull_pops", 64'(pops), 64'd261);
    check("qfull_span", 64'(last_hs - first_hs), 64'd264);

    // Reset at beat 2 of a len=7 burst
    new_test(64'h600);
    load_words(8);
    expect_burst(4'd7, 7, 1'b0);
    issue(4'd7, 8'd7, 1'b0, e0);
    for (int i = 0; i < 40 && hs_cnt < 2; i++) begin
      @(posedge rclk); #1;
    end
    check("rstmid_beats_before", 64'(hs_cnt), 64'd2);
    reset = 1'b1;
    @(posedge rclk); #1;
    check("rstmid_r_valid", 64'(r_valid), 64'd0);
    check("rstmid_fifo_read_en", 64'(fifo_read_en), 64'd0);
    check("rstmid_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rstmid_busy", 64'(busy), 64'd0);
    exp_q.delete();
    new_test(64'h700);
    reset = 1'b0;
    @(posedge rclk); #1;
    load_words(1);
    expect_burst(4'd2, 0, 1'b0);
    issue(4'd2, 8'd0, 1'b0, e0);
    check_latency("post_rst_latency", e0);
    wait_idle("post_rst", 50);
    check("post_rst_pops", 64'(pops), 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
